// File: rtl/mem_arbiter.sv
// Two-port block-memory arbiter between the icache and dcache memory-side ports.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin contention; otherwise the dcache wins ties.
module mem_arbiter #(
    parameter int ARB_ADDR_W = 28,
    parameter int ARB_DATA_W = 128
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    // icache side
    input  logic                  i_mem_read,
    input  logic [ARB_ADDR_W-1:0] i_mem_address,
    output logic [ARB_DATA_W-1:0] i_mem_readdata,
    output logic                  i_mem_busywait,
    // dcache side
    input  logic                  d_mem_read,
    input  logic                  d_mem_write,
    input  logic [ARB_ADDR_W-1:0] d_mem_address,
    input  logic [ARB_DATA_W-1:0] d_mem_writedata,
    output logic [ARB_DATA_W-1:0] d_mem_readdata,
    output logic                  d_mem_busywait,
    // main memory side
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ARB_ADDR_W-1:0] mem_address,
    output logic [ARB_DATA_W-1:0] mem_writedata,
    input  logic [ARB_DATA_W-1:0] mem_readdata,
    input  logic                  mem_busywait
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state;
    state_t idle_next;
    logic   last_grant;
    logic   d_lock;
    logic   i_req;
    logic   d_req;
    logic   tie_to_d;

    assign i_req = i_mem_read;
    assign d_req = d_mem_read | d_mem_write;

`ifdef ARB_ROUND_ROBIN_EN
    assign tie_to_d = ~last_grant;
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign tie_to_d          = 1'b1;
`endif

    // A completed write-back locks the next dcache request in ahead of any contention.
    always_comb begin
        idle_next = IDLE;
        if (d_lock && d_req)
            idle_next = SERVE_D;
        else if (i_req && d_req)
            idle_next = tie_to_d ? SERVE_D : SERVE_I;
        else if (d_req)
            idle_next = SERVE_D;
        else if (i_req)
            idle_next = SERVE_I;
    end

    always_ff @(negedge CLOCK) begin
        if (RESET) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            d_lock     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= idle_next;
                    if (idle_next != IDLE)
                        d_lock <= 1'b0;
                end
                SERVE_I: begin
                    if (!i_req) begin
                        state <= IDLE;
                    end else if (!mem_busywait) begin
                        state      <= IDLE;
                        last_grant <= 1'b0;
                    end
                end
                SERVE_D: begin
                    if (!d_req) begin
                        state <= IDLE;
                    end else if (!mem_busywait) begin
                        state      <= IDLE;
                        last_grant <= 1'b1;
                        if (d_mem_write)
                            d_lock <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Granted port drives memory directly; a read+write collision is treated as a write.
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_writedata  = '0;
        i_mem_busywait = i_req;
        d_mem_busywait = d_req;
        case (state)
            SERVE_I: begin
                mem_read       = i_mem_read;
                mem_address    = i_mem_address;
                i_mem_busywait = mem_busywait;
            end
            SERVE_D: begin
                mem_write      = d_mem_write;
                mem_read       = d_mem_read & ~d_mem_write;
                mem_address    = d_mem_address;
                mem_writedata  = d_mem_writedata;
                d_mem_busywait = mem_busywait;
            end
            default: ;
        endcase
    end

    assign i_mem_readdata = mem_readdata;
    assign d_mem_readdata = mem_readdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency block memory model.
module tb_mem_arbiter;
    localparam int AW  = 28;
    localparam int DW  = 128;
    localparam int LAT = 5;

    logic          CLOCK = 1'b1;
    logic          RESET;
    logic          i_mem_read;
    logic [AW-1:0] i_mem_address;
    logic [DW-1:0] i_mem_readdata;
    logic          i_mem_busywait;
    logic          d_mem_read;
    logic          d_mem_write;
    logic [AW-1:0] d_mem_address;
    logic [DW-1:0] d_mem_writedata;
    logic [DW-1:0] d_mem_readdata;
    logic          d_mem_busywait;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_writedata;
    logic [DW-1:0] mem_readdata;
    logic          mem_busywait;

    int checks = 0;
    int passes = 0;

    int            mem_cnt = 0;
    int            log_n   = 0;
    logic          log_wr   [32];
    logic [AW-1:0] log_addr [32];
    logic [DW-1:0] log_data [32];

    mem_arbiter #(.ARB_ADDR_W(AW), .ARB_DATA_W(DW)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
        .i_mem_readdata(i_mem_readdata), .i_mem_busywait(i_mem_busywait),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_address(d_mem_address), .d_mem_writedata(d_mem_writedata),
        .d_mem_readdata(d_mem_readdata), .d_mem_busywait(d_mem_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_busywait(mem_busywait)
    );

    always #5 CLOCK = ~CLOCK;

    // Memory: busy for LAT cycles after a request appears, then logs the completed transfer.
    assign mem_busywait = (mem_read | mem_write) && (mem_cnt < LAT);
    assign mem_readdata = {4{4'hA, mem_address}};

    always @(negedge CLOCK) begin
        if (mem_read | mem_write) begin
            mem_cnt <= mem_cnt + 1;
            if (!mem_busywait) begin
                log_wr[log_n % 32]   <= mem_write;
                log_addr[log_n % 32] <= mem_address;
                log_data[log_n % 32] <= mem_writedata;
                log_n                <= log_n + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    function automatic logic [DW-1:0] blk(input logic [AW-1:0] a);
        return {4{4'hA, a}};
    endfunction

    task automatic tick();
        @(negedge CLOCK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; i_mem_read = 1'b1; i_mem_address = 28'h10;
        d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0; d_mem_writedata = '0;
        tick(); tick(); #1;
        checks++; if (dut.state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dut.state); else passes++;
        checks++; if (dut.last_grant !== 1'b1) $display("FAIL reset_last_grant: got %b want 1", dut.last_grant); else passes++;
        checks++; if (dut.d_lock !== 1'b0) $display("FAIL reset_d_lock: got %b want 0", dut.d_lock); else passes++;
        checks++; if ({mem_read, mem_write} !== 2'b00) $display("FAIL reset_mem_rw: got %b want 00", {mem_read, mem_write}); else passes++;
        checks++; if (mem_address !== '0) $display("FAIL reset_mem_address: got %h want 0", mem_address); else passes++;
        checks++; if (i_mem_busywait !== 1'b1) $display("FAIL reset_i_busy_follows_req: got %b want 1", i_mem_busywait); else passes++;
        checks++; if (d_mem_busywait !== 1'b0) $display("FAIL reset_d_busy: got %b want 0", d_mem_busywait); else passes++;
        i_mem_read = 1'b0; RESET = 1'b0;
        tick(); tick();
        checks++; if (i_mem_busywait !== 1'b0) $display("FAIL idle_i_busy: got %b want 0", i_mem_busywait); else passes++;
    endtask

    task automatic test_lone_read();
        int bad;
        i_mem_address = 28'h0000010; i_mem_read = 1'b1; #1;
        checks++; if (mem_read !== 1'b0) $display("FAIL lone_c0_mem_read: got %b want 0", mem_read); else passes++;
        tick();
        checks++; if (mem_read !== 1'b1 || mem_address !== 28'h10) $display("FAIL lone_c1_grant: got rd=%b addr=%h want rd=1 addr=10", mem_read, mem_address); else passes++;
        checks++; if (d_mem_busywait !== 1'b0) $display("FAIL lone_c1_d_busy: got %b want 0", d_mem_busywait); else passes++;
        bad = 0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (i_mem_busywait !== 1'b1 || d_mem_busywait !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL lone_busy_window: got %0d bad cycles want 0", bad); else passes++;
        tick();
        checks++; if (i_mem_busywait !== 1'b0) $display("FAIL lone_c6_i_busy: got %b want 0", i_mem_busywait); else passes++;
        checks++; if (i_mem_readdata !== blk(28'h10)) $display("FAIL lone_readdata: got %h want %h", i_mem_readdata, blk(28'h10)); else passes++;
        tick(); i_mem_read = 1'b0; #1;
        checks++; if (mem_read !== 1'b0 || dut.state !== 2'd0) $display("FAIL lone_c7_idle: got rd=%b st=%0d want rd=0 st=0", mem_read, dut.state); else passes++;
        checks++; if (dut.last_grant !== 1'b0) $display("FAIL lone_last_grant: got %b want 0", dut.last_grant); else passes++;
        tick();
    endtask

    task automatic test_contention();
        int bad;
        logic first_d;
        logic [AW-1:0] win_a, lose_a;
        logic [DW-1:0] got;
`ifdef ARB_ROUND_ROBIN_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        win_a  = first_d ? 28'h20 : 28'h10;
        lose_a = first_d ? 28'h10 : 28'h20;
        RESET = 1'b1; tick(); RESET = 1'b0;
        i_mem_address = 28'h10; i_mem_read = 1'b1;
        d_mem_address = 28'h20; d_mem_read = 1'b1; #1;
        checks++; if ({i_mem_busywait, d_mem_busywait} !== 2'b11) $display("FAIL cont_c0_busy: got %b want 11", {i_mem_busywait, d_mem_busywait}); else passes++;
        tick();
        checks++; if (mem_read !== 1'b1 || mem_address !== win_a) $display("FAIL cont_first_grant: got rd=%b addr=%h want rd=1 addr=%h", mem_read, mem_address, win_a); else passes++;
        bad = 0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            if ({i_mem_busywait, d_mem_busywait} !== 2'b11) bad++;
        end
        tick();
        if ((first_d ? d_mem_busywait : i_mem_busywait) !== 1'b0) bad++;
        if ((first_d ? i_mem_busywait : d_mem_busywait) !== 1'b1) bad++;
        checks++; if (bad !== 0) $display("FAIL cont_first_busy: got %0d bad cycles want 0", bad); else passes++;
        got = first_d ? d_mem_readdata : i_mem_readdata;
        checks++; if (got !== blk(win_a)) $display("FAIL cont_first_data: got %h want %h", got, blk(win_a)); else passes++;
        tick();
        if (first_d) d_mem_read = 1'b0; else i_mem_read = 1'b0;
        #1;
        checks++; if (mem_read !== 1'b0) $display("FAIL cont_gap: got %b want 0", mem_read); else passes++;
        tick();
        checks++; if (mem_read !== 1'b1 || mem_address !== lose_a) $display("FAIL cont_second_grant: got rd=%b addr=%h want rd=1 addr=%h", mem_read, mem_address, lose_a); else passes++;
        for (int c = 9; c <= 13; c++) tick();
        got = first_d ? i_mem_readdata : d_mem_readdata;
        checks++; if (got !== blk(lose_a)) $display("FAIL cont_second_data: got %h want %h", got, blk(lose_a)); else passes++;
        tick(); i_mem_read = 1'b0; d_mem_read = 1'b0; #1;
        checks++; if (dut.last_grant !== ~first_d) $display("FAIL cont_last_grant: got %b want %b", dut.last_grant, ~first_d); else passes++;
        tick();
    endtask

    task automatic test_writeback_refill();
        int base;
        logic [DW-1:0] wd;
        base = log_n;
        wd = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
        d_mem_address = 28'h30; d_mem_writedata = wd; d_mem_write = 1'b1; #1;
        tick(); i_mem_address = 28'h50; i_mem_read = 1'b1; #1;
        checks++; if ({mem_write, mem_read} !== 2'b10 || mem_address !== 28'h30) $display("FAIL wb_grant: got wr/rd=%b addr=%h want 10 addr=30", {mem_write, mem_read}, mem_address); else passes++;
        checks++; if (mem_writedata !== wd) $display("FAIL wb_writedata: got %h want %h", mem_writedata, wd); else passes++;
        for (int c = 2; c <= 6; c++) tick();
        tick(); d_mem_write = 1'b0; d_mem_read = 1'b1; d_mem_address = 28'h40; #1;
        checks++; if (dut.d_lock !== 1'b1) $display("FAIL wb_d_lock_set: got %b want 1", dut.d_lock); else passes++;
        checks++; if ({mem_read, mem_write} !== 2'b00 || i_mem_busywait !== 1'b1) $display("FAIL wb_gap: got rw=%b ibusy=%b want 00 1", {mem_read, mem_write}, i_mem_busywait); else passes++;
        tick();
        checks++; if (mem_read !== 1'b1 || mem_address !== 28'h40) $display("FAIL wb_refill_grant: got rd=%b addr=%h want rd=1 addr=40", mem_read, mem_address); else passes++;
        checks++; if (dut.d_lock !== 1'b0) $display("FAIL wb_d_lock_clear: got %b want 0", dut.d_lock); else passes++;
        for (int c = 9; c <= 13; c++) tick();
        checks++; if (d_mem_readdata !== blk(28'h40)) $display("FAIL wb_refill_data: got %h want %h", d_mem_readdata, blk(28'h40)); else passes++;
        tick(); d_mem_read = 1'b0; #1;
        tick();
        checks++; if (mem_read !== 1'b1 || mem_address !== 28'h50) $display("FAIL wb_icache_after: got rd=%b addr=%h want rd=1 addr=50", mem_read, mem_address); else passes++;
        for (int c = 16; c <= 20; c++) tick();
        tick(); i_mem_read = 1'b0; #1;
        checks++; if (log_n !== base + 3) $display("FAIL wb_transfer_count: got %0d want %0d", log_n - base, 3); else passes++;
        checks++; if (log_wr[base % 32] !== 1'b1 || log_addr[base % 32] !== 28'h30 || log_data[base % 32] !== wd)
            $display("FAIL wb_order0: got wr=%b addr=%h want wr=1 addr=30", log_wr[base % 32], log_addr[base % 32]); else passes++;
        checks++; if (log_wr[(base + 1) % 32] !== 1'b0 || log_addr[(base + 1) % 32] !== 28'h40)
            $display("FAIL wb_order1: got wr=%b addr=%h want wr=0 addr=40", log_wr[(base + 1) % 32], log_addr[(base + 1) % 32]); else passes++;
        checks++; if (log_wr[(base + 2) % 32] !== 1'b0 || log_addr[(base + 2) % 32] !== 28'h50)
            $display("FAIL wb_order2: got wr=%b addr=%h want wr=0 addr=50", log_wr[(base + 2) % 32], log_addr[(base + 2) % 32]); else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        i_mem_address = 28'h10; i_mem_read = 1'b1; #1;
        for (int c = 1; c <= 6; c++) tick();
        checks++; if (mem_read !== 1'b1 || i_mem_busywait !== 1'b0) $display("FAIL b2b_first_done: got rd=%b busy=%b want 1 0", mem_read, i_mem_busywait); else passes++;
        tick(); i_mem_address = 28'h11; #1;
        checks++; if (mem_read !== 1'b0) $display("FAIL b2b_gap: got %b want 0", mem_read); else passes++;
        tick();
        checks++; if (mem_read !== 1'b1 || mem_address !== 28'h11) $display("FAIL b2b_second_grant: got rd=%b addr=%h want rd=1 addr=11", mem_read, mem_address); else passes++;
        for (int c = 9; c <= 13; c++) tick();
        checks++; if (i_mem_readdata !== blk(28'h11)) $display("FAIL b2b_data: got %h want %h", i_mem_readdata, blk(28'h11)); else passes++;
        tick(); i_mem_read = 1'b0; #1;
        tick();
    endtask

    task automatic test_reset_mid_serve_d();
        checks++; if (dut.last_grant !== 1'b0) $display("FAIL rst_mid_pre_last_grant: got %b want 0", dut.last_grant); else passes++;
        d_mem_address = 28'h20; d_mem_read = 1'b1; #1;
        tick(); tick(); RESET = 1'b1; #1;
        checks++; if (mem_read !== 1'b1) $display("FAIL rst_mid_still_serving: got %b want 1", mem_read); else passes++;
        tick();
        checks++; if (dut.state !== 2'd0) $display("FAIL rst_mid_state: got %0d want 0", dut.state); else passes++;
        checks++; if ({mem_read, mem_write} !== 2'b00 || mem_address !== '0) $display("FAIL rst_mid_mem: got rw=%b addr=%h want 00 0", {mem_read, mem_write}, mem_address); else passes++;
        checks++; if (dut.last_grant !== 1'b1 || dut.d_lock !== 1'b0) $display("FAIL rst_mid_regs: got lg=%b lock=%b want 1 0", dut.last_grant, dut.d_lock); else passes++;
        checks++; if (d_mem_busywait !== 1'b1) $display("FAIL rst_mid_d_busy: got %b want 1", d_mem_busywait); else passes++;
        RESET = 1'b0; d_mem_read = 1'b0;
        tick(); tick();
    endtask

    task automatic test_illegal_rw();
        logic [DW-1:0] wd;
        wd = {4{32'h5A5A_1234}};
        d_mem_address = 28'h60; d_mem_writedata = wd; d_mem_read = 1'b1; d_mem_write = 1'b1; #1;
        tick();
        checks++; if ({mem_write, mem_read} !== 2'b10) $display("FAIL illegal_as_write: got wr/rd=%b want 10", {mem_write, mem_read}); else passes++;
        checks++; if (mem_writedata !== wd || mem_address !== 28'h60) $display("FAIL illegal_payload: got addr=%h data=%h want 60 %h", mem_address, mem_writedata, wd); else passes++;
        for (int c = 2; c <= 6; c++) tick();
        tick(); d_mem_read = 1'b0; d_mem_write = 1'b0; #1;
        checks++; if (dut.d_lock !== 1'b1) $display("FAIL illegal_d_lock: got %b want 1", dut.d_lock); else passes++;
        RESET = 1'b1;
        tick();
        checks++; if (dut.d_lock !== 1'b0) $display("FAIL reset_clears_d_lock: got %b want 0", dut.d_lock); else passes++;
        RESET = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lone_read();
        test_contention();
        test_writeback_refill();
        test_back_to_back();
        test_reset_mid_serve_d();
        test_illegal_rw();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
